// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock. Optional signed overflow
// flag is built only when SERIAL_SUB_OVF_EN is defined; otherwise ovf is tied low.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one difference bit per cycle, WIDTH cycles
//   DONE  | one-cycle done pulse, then back to IDLE
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d_bit;
    logic             bout_bit;
    logic             accept;
    logic             last_shift;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign accept     = (state == IDLE) && start;
    assign last_shift = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bin   <= 1'b0;
                        diff  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    bin  <= bout_bit;
                    cnt  <= cnt + CW'(1);
                    // Only the final borrow is published; intermediate ones stay in bin.
                    if (cnt == LAST) begin
                        borrow <= bout_bit;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // The new diff MSB is the bit being shifted in on the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last_shift) begin
            ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = accept ^ last_shift;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 8): directed vectors push
// expected results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    localparam int W = 8;

`ifdef SERIAL_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic br, input logic ov);
        exp_t e;
        e.diff   = d;
        e.borrow = br;
        e.ovf    = ov;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            check("busy_low_in_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("diff", {24'd0, diff}, {24'd0, mon_e.diff});
                check("borrow", {31'd0, borrow}, {31'd0, mon_e.borrow});
                check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
            end
        end
    end

    // One start pulse, then wait for done; done must appear WIDTH+1 negedges after E0.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
        bit found;
        found = 1'b0;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
            if (done) begin
                check("done_latency", k, W + 1);
                found = 1'b1;
                break;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int first_k;
        int second_k;
        int dones_before;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0));
        run_op(8'h03, 8'h05, mk(8'hFE, 1'b1, 1'b0));
        run_op(8'h80, 8'h01, mk(8'h7F, 1'b0, OVF_ON));
        @(negedge clk);
        check("result_hold_idle", {24'd0, diff}, 32'h7F);

        // Back-to-back with start held high
        first_k = 0;
        second_k = 0;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        sb.push_back(mk(8'h00, 1'b0, 1'b0));
        sb.push_back(mk(8'hFF, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        a = 8'h00;
        b = 8'h01;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 10) check("b2b_idle_gap_busy", {31'd0, busy}, 32'd0);
            if (k == 11) begin
                check("b2b_second_busy", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
            if (done && first_k == 0) first_k = k;
            else if (done && second_k == 0) second_k = k;
            if (second_k != 0) break;
        end
        check("b2b_first_done", first_k, W + 1);
        check("b2b_second_done", second_k, 2 * W + 3);

        // Start pulse mid-operation must be ignored
        repeat (2) @(negedge clk);
        dones_before = done_seen;
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        sb.push_back(mk(8'h02, 1'b0, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a = 8'hAA;
                b = 8'h11;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        check("ignored_start_done_count", done_seen - dones_before, 32'd1);

        // Asynchronous reset between E4 and E5
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        sb.push_back(mk(8'h02, 1'b0, 1'b0));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h01, mk(8'h0F, 1'b0, 1'b0));

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
